// File: rtl/serial_frame_loader_pkg.sv
// serial_frame_loader_pkg: shared state encoding, default sizes and helpers for the serial frame loader.
package serial_frame_loader_pkg;
  typedef enum logic [1:0] {IDLE, KEY_SHIFT, MSG_SHIFT, HOLD} state_e;
  localparam int MSG_SIZE_DEF = 64;
  localparam int KEY_SIZE_DEF = 8;
  function automatic int cnt_width(input int size);
    return $clog2(size + 2);
  endfunction
  function automatic logic parity_next(input logic par, input logic bit_in);
    return par ^ bit_in;
  endfunction
endpackage

// File: rtl/serial_shift_counter.sv
// serial_shift_counter: MSB-first shift register with saturating bit counter and running parity.
module serial_shift_counter
  import serial_frame_loader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] shreg_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             par_o
);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(WIDTH + 1);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  always_comb begin
    shreg_d = (start_i || shift_i) ? {shreg_q[WIDTH-2:0], ser_i} : shreg_q;
    cnt_d   = start_i ? CNT_W'(1) : (shift_i && cnt_q != SAT) ? cnt_q + CNT_W'(1) : cnt_q;
    par_d   = start_i ? ser_i : shift_i ? parity_next(par_q, ser_i) : par_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end
  assign shreg_o = shreg_q;
  assign cnt_o   = cnt_q;
  assign par_o   = par_q;
endmodule

// File: rtl/serial_frame_loader.sv
// serial_frame_loader: deserializes key and message frames from one serial pin for the cipher core.
// SERIAL_FRAME_LOADER_PARITY_EN adds a trailing even-parity bit to every frame.
module serial_frame_loader
  import serial_frame_loader_pkg::*;
#(
  parameter int MSG_SIZE = MSG_SIZE_DEF,
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int CNT_W    = cnt_width(MSG_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ser_in,
  input  logic                key_load,
  input  logic                msg_load,
  output logic [KEY_SIZE-1:0] key_data,
  output logic                key_valid,
  output logic [MSG_SIZE-1:0] msg_data,
  output logic                msg_valid,
  input  logic                msg_ready,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun
);
`ifdef SERIAL_FRAME_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int KW = KEY_SIZE + PB;
  localparam int MW = MSG_SIZE + PB;
  localparam logic [CNT_W-1:0] KE = CNT_W'(KW);
  localparam logic [CNT_W-1:0] ME = CNT_W'(MW);
  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_data_q, key_data_d;
  logic [MSG_SIZE-1:0] msg_data_q, msg_data_d;
  logic                key_valid_q, key_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                key_load_q, msg_load_q;
  logic                k_start, k_shift, m_start, m_shift, k_par, m_par, k_ok, m_ok, hold_err;
  logic [KW-1:0]       k_sh;
  logic [MW-1:0]       m_sh;
  logic [CNT_W-1:0]    k_cnt, m_cnt;
  serial_shift_counter #(.WIDTH(KW), .CNT_W(CNT_W)) u_key (
    .clk(clk), .rst(rst), .start_i(k_start), .shift_i(k_shift), .ser_i(ser_in),
    .shreg_o(k_sh), .cnt_o(k_cnt), .par_o(k_par)
  );
  serial_shift_counter #(.WIDTH(MW), .CNT_W(CNT_W)) u_msg (
    .clk(clk), .rst(rst), .start_i(m_start), .shift_i(m_shift), .ser_i(ser_in),
    .shreg_o(m_sh), .cnt_o(m_cnt), .par_o(m_par)
  );
  // With parity the count must be exact; without it, extra bits are tolerated as overrun.
  assign k_ok     = (PB != 0) ? (k_cnt == KE && !k_par) : (k_cnt >= KE);
  assign m_ok     = (PB != 0) ? (m_cnt == ME && !m_par) : (m_cnt >= ME);
  assign hold_err = (key_load && !key_load_q) || (msg_load && !msg_load_q);
  always_comb begin
    state_d     = state_q;
    key_data_d  = key_data_q;
    key_valid_d = key_valid_q;
    msg_data_d  = msg_data_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    k_start     = 1'b0;
    k_shift     = 1'b0;
    m_start     = 1'b0;
    m_shift     = 1'b0;
    case (state_q)
      IDLE: begin
        k_start     = key_load;
        m_start     = msg_load && !key_load;
        frame_err_d = key_load && msg_load;
        overrun_d   = (key_load || msg_load) ? 1'b0 : overrun_q;
        state_d     = key_load ? KEY_SHIFT : msg_load ? MSG_SHIFT : IDLE;
      end
      KEY_SHIFT: begin
        k_shift     = key_load;
        state_d     = key_load ? KEY_SHIFT : IDLE;
        key_data_d  = (!key_load && k_ok) ? k_sh[KW-1 -: KEY_SIZE] : key_data_q;
        key_valid_d = key_valid_q || (!key_load && k_ok);
        frame_err_d = !key_load && !k_ok;
        overrun_d   = key_load ? overrun_q : (k_cnt > KE);
      end
      MSG_SHIFT: begin
        m_shift     = msg_load;
        state_d     = msg_load ? MSG_SHIFT : m_ok ? HOLD : IDLE;
        msg_data_d  = (!msg_load && m_ok) ? m_sh[MW-1 -: MSG_SIZE] : msg_data_q;
        frame_err_d = !msg_load && !m_ok;
        overrun_d   = msg_load ? overrun_q : (m_cnt > ME);
      end
      HOLD: begin
        frame_err_d = hold_err;
        state_d     = msg_ready ? IDLE : HOLD;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_data_q  <= '0;
      key_valid_q <= 1'b0;
      msg_data_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      key_load_q  <= 1'b0;
      msg_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
      msg_data_q  <= msg_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      key_load_q  <= key_load;
      msg_load_q  <= msg_load;
    end
  end
  assign key_data  = key_data_q;
  assign key_valid = key_valid_q;
  assign msg_data  = msg_data_q;
  assign msg_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_serial_frame_loader.sv
// tb_serial_frame_loader: directed frame table plus hand-written corner sequences for serial_frame_loader.
module tb_serial_frame_loader;
  logic        clk = 1'b0, rst = 1'b1, ser_in = 1'b0, key_load = 1'b0, msg_load = 1'b0, msg_ready = 1'b0;
  logic [7:0]  key_data;
  logic [63:0] msg_data;
  logic        key_valid, msg_valid, busy, frame_err, overrun;
  int          errors = 0, checks = 0;

  serial_frame_loader dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .key_load(key_load), .msg_load(msg_load),
    .key_data(key_data), .key_valid(key_valid), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        key;
    int          n;
    logic [65:0] bits;
    logic        err;
    logic        ovr;
    logic [7:0]  kd;
    logic        mv;
    logic [63:0] md;
  } vec_t;
  vec_t tv[8];

  localparam logic [63:0] W1 = 64'hA3B1F9D2E7C6A594;
  localparam logic [63:0] W2 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W3 = 64'hFEDCBA9876543210;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic key, input int n, input logic [65:0] bits, input logic close);
    for (int i = n - 1; i >= 0; i--) begin
      key_load = key;
      msg_load = !key;
      ser_in   = bits[i];
      step();
    end
    if (close) begin
      key_load = 1'b0;
      msg_load = 1'b0;
      ser_in   = 1'b0;
      step();
    end
  endtask

  task automatic accept();
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
  endtask

  initial begin
    tv[0] = '{1'b1, 8,  66'hA5,             1'b0, 1'b0, 8'hA5, 1'b0, 64'h0};
    tv[1] = '{1'b0, 64, {2'b00, W1},        1'b0, 1'b0, 8'hA5, 1'b1, W1};
    tv[2] = '{1'b1, 5,  66'h15,             1'b1, 1'b0, 8'hA5, 1'b0, W1};
    tv[3] = '{1'b0, 66, {2'b10, W2},        1'b0, 1'b1, 8'hA5, 1'b1, W2};
    tv[4] = '{1'b1, 8,  66'h3C,             1'b0, 1'b0, 8'h3C, 1'b0, W2};
    tv[5] = '{1'b0, 10, 66'h2AB,            1'b1, 1'b0, 8'h3C, 1'b0, W2};
    tv[6] = '{1'b1, 9,  66'h15A,            1'b0, 1'b1, 8'h5A, 1'b0, W2};
    tv[7] = '{1'b0, 64, {2'b00, W3},        1'b0, 1'b0, 8'h5A, 1'b1, W3};

    #2;
    chk("reset key_valid", key_valid, 0);
    chk("reset msg_valid", msg_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset key_data", key_data, 0);
    @(negedge clk) rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      send(tv[i].key, tv[i].n, tv[i].bits, 1'b1);
      chk($sformatf("v%0d frame_err", i), frame_err, tv[i].err);
      chk($sformatf("v%0d overrun", i), overrun, tv[i].ovr);
      chk($sformatf("v%0d key_data", i), key_data, tv[i].kd);
      chk($sformatf("v%0d key_valid", i), key_valid, 1);
      chk($sformatf("v%0d msg_valid", i), msg_valid, tv[i].mv);
      chk($sformatf("v%0d busy", i), busy, tv[i].mv);
      chk($sformatf("v%0d msg_data", i), msg_data, tv[i].md);
      if (tv[i].mv) begin
        accept();
        chk($sformatf("v%0d msg_valid after accept", i), msg_valid, 0);
      end else step();
      chk($sformatf("v%0d frame_err cleared", i), frame_err, 0);
    end

    // Message held for 10 cycles with msg_ready low, then accepted.
    send(1'b0, 64, {2'b00, W1}, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d msg_valid", i), msg_valid, 1);
      chk($sformatf("hold%0d msg_data", i), msg_data, W1);
      step();
    end
    accept();
    chk("hold release msg_valid", msg_valid, 0);
    chk("hold release busy", busy, 0);

    // Strobes during HOLD are ignored; one error pulse per rising edge.
    send(1'b0, 64, {2'b00, W2}, 1'b1);
    msg_load = 1'b1;
    step();
    chk("hold msg_load err", frame_err, 1);
    step();
    chk("hold msg_load held no err", frame_err, 0);
    msg_load = 1'b0;
    key_load = 1'b1;
    step();
    chk("hold key_load err", frame_err, 1);
    key_load = 1'b0;
    step();
    chk("hold strobe msg_data", msg_data, W2);
    chk("hold strobe msg_valid", msg_valid, 1);
    accept();
    chk("hold strobe released", busy, 0);

    // Both strobes in IDLE: key path wins, error pulses.
    key_load = 1'b1;
    msg_load = 1'b1;
    ser_in   = 1'b1;
    step();
    chk("conflict frame_err", frame_err, 1);
    chk("conflict busy", busy, 1);
    msg_load = 1'b0;
    send(1'b1, 7, 66'h43, 1'b1);
    chk("conflict key_data", key_data, 8'hC3);
    chk("conflict msg_valid", msg_valid, 0);
    chk("conflict frame_err end", frame_err, 0);

    // msg_ready without a pending message is harmless.
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
    chk("idle ready busy", busy, 0);
    chk("idle ready msg_valid", msg_valid, 0);

    // Async reset at bit 30 of a message frame.
    send(1'b0, 30, {2'b00, W3}, 1'b0);
    chk("pre-reset busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst key_valid", key_valid, 0);
    chk("async rst key_data", key_data, 0);
    chk("async rst msg_data", msg_data, 0);
    chk("async rst msg_valid", msg_valid, 0);
    msg_load = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();
    send(1'b1, 8, 66'h96, 1'b1);
    chk("post-rst key_data", key_data, 8'h96);
    chk("post-rst key_valid", key_valid, 1);
    send(1'b0, 64, {2'b00, W3}, 1'b1);
    chk("post-rst msg_valid", msg_valid, 1);
    chk("post-rst msg_data", msg_data, W3);
    accept();
    chk("post-rst released", msg_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_frame_loader.md
Name: serial_frame_loader

Overview:
- Upstream input stage for the XOR cipher core.
- Deserializes the key and the message from the single serial pin, MSB-first, under the ui_in[1] (key) and ui_in[2] (message) load strobes.
- Presents the parallel key word continuously and the message word through a valid/ready handshake, one cycle after the frame closes.
- The cipher core consumes msg_data/key_data and raises msg_ready when it accepts.

Parameters:
- MSG_SIZE, 64: message frame width in bits.
- KEY_SIZE, 8: key frame width in bits.
- CNT_W, $clog2(MSG_SIZE+2): bit-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial data bit (ui_in[0]).
- key_load  in  1  key frame strobe (ui_in[1]).
- msg_load  in  1  message frame strobe (ui_in[2]).
- key_data  out  KEY_SIZE  last accepted key.
- key_valid  out  1  sticky; high once a key frame has been accepted.
- msg_data  out  MSG_SIZE  accepted message word.
- msg_valid  out  1  message word available to the core.
- msg_ready  in  1  core accepts msg_data when msg_valid & msg_ready.
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- overrun  out  1  sticky; too many bits were seen in the last frame. Cleared at the next frame start.

Behaviour:
- Reset (async, rst=1): all outputs 0, shift registers 0, counter 0, state IDLE. Reset mid-frame or mid-handshake drops everything, including key_valid.
- States: IDLE, KEY_SHIFT, MSG_SHIFT, HOLD.
- IDLE, key_load=1: go to KEY_SHIFT. The bit sampled in this same cycle is the first bit; the counter is set to 1.
- IDLE, msg_load=1 and key_load=0: go to MSG_SHIFT, with the same first-bit rule.
- IDLE, both strobes high: key_load wins; msg_load is ignored and frame_err pulses.
- KEY_SHIFT, each cycle with key_load=1: shreg <= {shreg[KEY_SIZE-2:0], ser_in}. The counter increments and saturates at KEY_SIZE+1.
- KEY_SHIFT, key_load falls with count==KEY_SIZE: key_data <= shreg, key_valid=1 next cycle, back to IDLE.
- KEY_SHIFT, key_load falls with count<KEY_SIZE: discard the frame, pulse frame_err, keep the old key, go to IDLE.
- KEY_SHIFT, count>KEY_SIZE: the last KEY_SIZE bits are kept, the frame is accepted, and overrun is set.
- MSG_SHIFT: same rules with MSG_SIZE. On a good close, msg_data is loaded and state goes to HOLD with msg_valid=1 next cycle. Latency is 1 clk from the strobe falling edge sample to msg_valid.
- MSG_SHIFT: key_load is ignored; no error.
- HOLD: msg_valid stays high and msg_data is stable until msg_valid & msg_ready. msg_valid drops the following cycle and the state returns to IDLE.
- HOLD: any strobe is ignored and frame_err pulses once per strobe rising edge.
- msg_ready while msg_valid=0 has no effect.
- busy = (state != IDLE).

Optional Feature:
- Macro: SERIAL_FRAME_LOADER_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing even-parity bit, so the expected count is SIZE+1.
  - The parity bit is not stored.
  - On a parity mismatch, or a count not equal to SIZE+1, the frame is discarded and frame_err pulses.
  - Overrun checking uses SIZE+1.
- Undefined: no parity bit; behaviour exactly as above.

Decomposition:
- Package serial_frame_loader_pkg holds:
  - the state enum (IDLE, KEY_SHIFT, MSG_SHIFT, HOLD);
  - default MSG_SIZE and KEY_SIZE constants;
  - a count-width function;
  - the parity helper function.
- One sub-module, serial_shift_counter (parameter WIDTH): MSB-first shift register, saturating bit counter, running parity. It is instantiated twice, once for key and once for message.
- The FSM and handshake live in the top level.

Test Plan:
- Key load: key_load high for 8 clk shifting 0xA5 -> key_data=0xA5, key_valid=1 one clk after the strobe drops, frame_err=0.
- Message load: msg_load high for 64 clk shifting 0xA3B1F9D2E7C6A594, msg_ready=0 -> msg_data matches, msg_valid held for 10 clk. Raising msg_ready for 1 clk -> msg_valid=0 next clk, busy=0.
- Short frame: key 0xA5 loaded first, then key_load for only 5 bits -> frame_err pulses 1 clk, key_data stays 0xA5.
- Overrun: msg_load for 66 bits -> last 64 bits captured, overrun=1. A following good frame clears overrun.
- Conflicts:
  - key_load and msg_load asserted together -> key path taken, frame_err pulses.
  - msg_load during HOLD -> ignored, msg_data unchanged.
- Async reset mid MSG_SHIFT (bit 30) -> all outputs 0 immediately, without waiting for a clock edge. Next full key plus message sequence loads correctly.
